// File: rtl/hub75_framebuffer_pwm_if.sv
// hub75_framebuffer_pwm_if
//   Producer-side bus of the HUB75 double-buffered framebuffer.
//   master : the pixel producer (drives pixel writes and swap requests).
//   slave  : the framebuffer (answers with wr_ready, swap_ack, front_bank).
//
//   Write handshake: a pixel transfers on the rising clock edge where
//   wr_valid && wr_ready are both high.
//   - The master may raise wr_valid at any time.
//   - While wr_valid is high, wr_x/wr_y/wr_rgb must stay stable until the transfer.
//   - wr_ready never depends on wr_valid.
//   swap_req is a single-cycle pulse. swap_ack is a single-cycle pulse.
interface hub75_framebuffer_pwm_if #(
  parameter int COLS       = 64,
  parameter int ROW_ADDR_W = 4,
  parameter int BPC        = 2
);
  localparam int COL_W = $clog2(COLS);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [COL_W-1:0]      wr_x;
  logic [ROW_ADDR_W:0]   wr_y;
  logic [3*BPC-1:0]      wr_rgb;
  logic                  swap_req;
  logic                  swap_ack;
  logic                  front_bank;

  modport master (
    output wr_valid, wr_x, wr_y, wr_rgb, swap_req,
    input  wr_ready, swap_ack, front_bank
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_rgb, swap_req,
    output wr_ready, swap_ack, front_bank
  );
endinterface

// File: rtl/hub75_framebuffer_pwm.sv
// hub75_framebuffer_pwm
//   Double-buffered framebuffer for the HUB75 panel driver.
//   - The producer writes pixels into the back bank.
//   - The driver reads the front bank by {ADDR, column}.
//   - The driver receives PWM-sliced 1-bit RGB for the top half (RGB0) and the
//     bottom half (RGB1) of the panel.
//   - A requested bank swap only takes effect at the end of a full PWM period.
//
// Ports
//   clk, rst_n  : clock, synchronous active-low reset
//   column/ADDR : read position from the driver. RGB0/RGB1 follow 2 cycles later.
//   frame_done  : driver pulse, advances the PWM slice counter
//   RGB0/RGB1   : {R,G,B} PWM bits for the top and bottom halves
//   dbg_state   : swap/clear state machine state (swap_state_t encoding)
//   wr          : producer bus (pixel writes, swap request/ack, front_bank)
//
// Build option
//   FB_AUTOCLEAR_EN : when defined, the new back bank is zeroed after reset and
//                     after every swap. The sweep writes one pixel per half per
//                     cycle, and wr_ready is held low while it runs.
module hub75_framebuffer_pwm #(
  parameter  int COLS       = 64,
  parameter  int ROW_ADDR_W = 4,
  parameter  int BPC        = 2,
  localparam int COL_W      = $clog2(COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COL_W-1:0]      column,
  input  logic [ROW_ADDR_W-1:0] ADDR,
  input  logic                  frame_done,
  output logic [2:0]            RGB0,
  output logic [2:0]            RGB1,
  output logic [1:0]            dbg_state,
  hub75_framebuffer_pwm_if.slave wr
);

  localparam int HALF_DEPTH = (2 ** ROW_ADDR_W) * COLS;
  localparam int AW         = ROW_ADDR_W + COL_W;
  localparam int PW         = 3 * BPC;
  // Last slice of a PWM period: the period is 2^BPC-1 frames long, so a full
  // scale channel value is on in every slice.
  localparam logic [BPC-1:0] CNT_LAST = BPC'((1 << BPC) - 2);

  typedef enum logic [1:0] {
    ST_IDLE,        // back bank writable
    ST_PENDING,     // swap requested, waiting for period end
    ST_CLEAR,       // sweeping the back bank to zero
    ST_CLEAR_PEND   // sweeping, with a swap already requested
  } swap_state_t;

`ifdef FB_AUTOCLEAR_EN
  localparam swap_state_t RESET_STATE = ST_CLEAR;
  localparam swap_state_t AFTER_SWAP  = ST_CLEAR;
`else
  localparam swap_state_t RESET_STATE = ST_IDLE;
  localparam swap_state_t AFTER_SWAP  = ST_IDLE;
`endif

  swap_state_t     state_q, state_d;
  logic            front_bank_q;
  logic [BPC-1:0]  cycle_cnt_q;
  logic            swap_ack_q;
  logic            period_end;
  logic            do_swap;
  logic            sweep_last;

  // Bank bit is the address MSB. The top and bottom halves are separate arrays,
  // so both halves can be read in the same cycle.
  logic [PW-1:0]   mem_top [2*HALF_DEPTH];
  logic [PW-1:0]   mem_bot [2*HALF_DEPTH];
  logic [PW-1:0]   rd_top, rd_bot;
  logic [AW:0]     rd_addr;
  logic [AW:0]     wr_addr;
  logic [PW-1:0]   wr_data;
  logic            wr_accept;
  logic            top_we, bot_we;

`ifdef FB_AUTOCLEAR_EN
  logic [AW-1:0]   sweep_cnt;
  logic            clearing;

  assign clearing   = (state_q == ST_CLEAR) || (state_q == ST_CLEAR_PEND);
  assign sweep_last = clearing && (sweep_cnt == '1);

  always_ff @(posedge clk) begin
    if (!rst_n)        sweep_cnt <= '0;
    else if (clearing) sweep_cnt <= sweep_cnt + 1'b1;
  end
`else
  assign sweep_last = 1'b0;
`endif

  assign period_end    = frame_done && (cycle_cnt_q == CNT_LAST);
  assign wr.wr_ready   = (state_q == ST_IDLE);
  assign wr.swap_ack   = swap_ack_q;
  assign wr.front_bank = front_bank_q;
  assign dbg_state     = state_q;

  // Swap / clear state machine
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr.swap_req) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (period_end) begin
          do_swap = 1'b1;
          state_d = AFTER_SWAP;
        end
      end
      ST_CLEAR: begin
        if (sweep_last)       state_d = wr.swap_req ? ST_PENDING : ST_IDLE;
        else if (wr.swap_req) state_d = ST_CLEAR_PEND;
      end
      ST_CLEAR_PEND: begin
        // A period end during the sweep is deliberately ignored.
        if (sweep_last) state_d = ST_PENDING;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bank select, PWM slice counter, swap acknowledge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      front_bank_q <= 1'b0;
      cycle_cnt_q  <= '0;
      swap_ack_q   <= 1'b0;
    end else begin
      swap_ack_q <= do_swap;
      if (do_swap) front_bank_q <= ~front_bank_q;
      if (frame_done)
        cycle_cnt_q <= (cycle_cnt_q == CNT_LAST) ? '0 : cycle_cnt_q + 1'b1;
    end
  end

  // Write port: producer pixels, or the clear sweep (which owns the port
  // whenever it runs, since wr_ready is low then). Always targets the back bank.
  always_comb begin
    wr_accept = rst_n && wr.wr_valid && wr.wr_ready;
    top_we    = wr_accept && !wr.wr_y[ROW_ADDR_W];
    bot_we    = wr_accept &&  wr.wr_y[ROW_ADDR_W];
    wr_addr   = {~front_bank_q, wr.wr_y[ROW_ADDR_W-1:0], wr.wr_x};
    wr_data   = wr.wr_rgb;
`ifdef FB_AUTOCLEAR_EN
    if (clearing) begin
      top_we  = 1'b1;
      bot_we  = 1'b1;
      wr_addr = {~front_bank_q, sweep_cnt};
      wr_data = '0;
    end
`endif
  end

  assign rd_addr = {front_bank_q, ADDR, column};

  always_ff @(posedge clk) begin
    if (top_we) mem_top[wr_addr] <= wr_data;
    if (bot_we) mem_bot[wr_addr] <= wr_data;
    rd_top <= mem_top[rd_addr];
    rd_bot <= mem_bot[rd_addr];
  end

  // Each channel is lit for the first 'value' slices of the period.
  function automatic logic [2:0] pwm_bits(input logic [PW-1:0] px,
                                          input logic [BPC-1:0] cnt);
    pwm_bits = {cnt < px[3*BPC-1:2*BPC], cnt < px[2*BPC-1:BPC], cnt < px[BPC-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RGB0 <= 3'b000;
      RGB1 <= 3'b000;
    end else begin
      RGB0 <= pwm_bits(rd_top, cycle_cnt_q);
      RGB1 <= pwm_bits(rd_bot, cycle_cnt_q);
    end
  end

endmodule

// File: doc/hub75_framebuffer_pwm.md
Name: hub75_framebuffer_pwm

Overview:
- Parametrised, writable, double-buffered framebuffer for the HUB75 panel driver.
- Holds two banks of 2*2^ROW_ADDR_W rows x COLS pixels, with BPC bits per colour channel.
- A producer writes pixels into the back bank. The driver reads the front bank through the existing column/ADDR interface and receives PWM-sliced 1-bit RGB0/RGB1.
- Bank swap is requested by the producer and only takes effect at the end of a complete PWM period, so there is no tearing.

Parameters:
- COLS, 64, pixels per row; must be a power of 2; COL_W = log2(COLS).
- ROW_ADDR_W, 4, width of ADDR; the panel has 2*2^ROW_ADDR_W rows (top half feeds RGB0, bottom half feeds RGB1).
- BPC, 2, bits per colour channel (1..4); pixel word = 3*BPC bits, packed {R,G,B}.

Ports:
- clk  in  1  main clock.
- rst_n  in  1  reset, synchronous, active-low.
- column  in  COL_W  read column from the driver.
- ADDR  in  ROW_ADDR_W  read row address from the driver.
- frame_done  in  1  one-cycle pulse from the driver after all rows have been shifted out once.
- RGB0  out  3  top-half PWM bits {R,G,B}.
- RGB1  out  3  bottom-half PWM bits {R,G,B}.
- wr_valid  in  1  write request.
- wr_ready  out  1  write port can accept.
- wr_x  in  COL_W  pixel column.
- wr_y  in  ROW_ADDR_W+1  pixel row; MSB=1 selects the bottom half.
- wr_rgb  in  3*BPC  pixel value.
- swap_req  in  1  one-cycle pulse requesting a bank swap.
- swap_ack  out  1  one-cycle pulse in the cycle after the swap takes effect.
- front_bank  out  1  currently displayed bank.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - front_bank=0, cycle_cnt=0, swap_pending=0, swap_ack=0, RGB0=RGB1=0, wr_ready=1.
  - Memory contents are not reset.
- Read path:
  - Address {ADDR,column} into the front bank; top and bottom halves are read in parallel.
  - Synchronous RAM, then registered compare: RGBx is valid 2 cycles after column/ADDR.
  - Per channel, bit = (cycle_cnt < channel_value).
- PWM counter cycle_cnt (BPC bits):
  - Increments on frame_done and wraps from 2^BPC-2 to 0. The period is 2^BPC-1 frames.
  - Channel value 2^BPC-1 is therefore always on, and 0 is always off.
- Write path:
  - A write is accepted when wr_valid && wr_ready, and stores wr_rgb at (wr_y, wr_x) in bank ~front_bank on that edge.
  - No write ever lands in the front bank.
  - wr_ready = !swap_pending (and not clearing, see the optional feature).
- Swap:
  - swap_req with swap_pending=0 sets swap_pending on the next edge.
  - swap_req while swap_pending=1 is ignored; requests are not queued.
  - When swap_pending && frame_done && cycle_cnt==2^BPC-2, all of the following happen on that edge: front_bank toggles, swap_pending clears, and cycle_cnt wraps to 0.
  - swap_ack is high for the following cycle.
  - Reads in the cycle of the swap edge still use the old bank.
- Simultaneous events:
  - A write accepted in the same cycle as swap_req goes to the old back bank. wr_ready drops on the next cycle.
  - frame_done and swap_req in the same cycle: swap_req only sets pending. The swap waits for a later period end.
- Reset mid-operation aborts any pending swap or clear. Partial writes already performed stay in memory.

Optional Feature:
- Macro: FB_AUTOCLEAR_EN.
- Defined:
  - After each swap, and after reset, an internal sweep writes 0 to every address of the new back bank, one pixel per half per cycle, for 2^ROW_ADDR_W*COLS cycles.
  - wr_ready=0 during the sweep.
  - swap_req during the sweep is accepted as pending. That swap cannot take effect before the sweep ends; if a period end arrives mid-sweep, the swap waits for the next period end.
- Undefined:
  - No sweep; the back bank keeps stale contents.
  - wr_ready depends only on swap_pending.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> RGB0=RGB1=0, front_bank=0, wr_ready=1, swap_ack=0 (with AUTOCLEAR: wr_ready=0 for exactly 1024 cycles at default parameters).
- Write then swap: write (y=5,x=10,rgb=6'b11_01_00) and (y=21,x=10,rgb=6'b00_10_11), then pulse swap_req, then pulse frame_done 3 times -> swap_ack on the cycle after the 3rd pulse, front_bank=1. With ADDR=5, column=10:
  - cycle_cnt=0: RGB0=3'b110, RGB1=3'b011.
  - cycle_cnt=1: RGB0=3'b100, RGB1=3'b011.
  - cycle_cnt=2: RGB0=3'b100, RGB1=3'b001.
- Tearing guard: with swap_pending=1, wr_valid held high -> no acceptance, back-bank pixel unchanged; a second swap_req produces only one swap_ack.
- Front-bank isolation: write to (0,0) before any swap -> RGB0 at ADDR=0, column=0 stays at its pre-write value on every cycle_cnt.
- Latency: step column 0->1->2 every cycle -> RGB output tracks each column exactly 2 cycles later.
- Reset mid-pending: swap_req, 1 frame_done, then rst_n=0 for 1 cycle -> front_bank=0, no swap_ack, wr_ready=1 (non-AUTOCLEAR build).
